fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- single-outstanding instruction fetch stage.
//
// Requests one word from instruction memory at pc_out, holds it for the
// downstream decode/execute logic, and when the held instruction is consumed
// computes the next PC (jump, taken branch or sequential). A request that
// waits TIMEOUT_CYCLES without imem_ready parks the unit in a sticky ERROR
// state that only reset clears.
//
// Parameters
//   RESET_PC        address of the first fetch after reset
//   TIMEOUT_CYCLES  max wait cycles for imem_ready (0 disables the timeout)
//
// Ports
//   clock, reset_n               rising-edge clock, async active-low reset
//   imem_req/imem_addr           memory read request and byte address
//   imem_ready/imem_rdata        memory response (data valid when ready)
//   instruction/instr_valid      held instruction word and its valid flag
//   pc_out                       address of the held/requested instruction
//   instr_accept                 downstream consumes the held instruction
//   branch_eq/branch_ne/jump     decode of the held instruction
//   zero_flag                    ALU zero result for the held instruction
//   branch_offset                sign-extended branch immediate
//   jump_index                   instruction[25:0] of the held instruction
//   fetch_error                  sticky memory-timeout indication
//   fetch_count                  completed-fetch counter (FETCH_PERF_CNT_EN)
//
// Build option: define FETCH_PERF_CNT_EN to add the fetch_count output.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    input  logic        instr_accept,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        zero_flag,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic        fetch_error
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    // Wait counter only needs to reach TIMEOUT_CYCLES-1 before the abort.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [31:0]    pc4;
    logic [31:0]    next_pc;
    logic           taken;

    // Next-PC selection: jump beats branch beats sequential.
    assign pc4   = pc_q + 32'd4;
    assign taken = (branch_eq & zero_flag) | (branch_ne & ~zero_flag);

    always_comb begin
        next_pc = pc4;
        if (jump)
            next_pc = {pc4[31:28], jump_index, 2'b00};
        else if (taken)
            next_pc = pc4 + {branch_offset[29:0], 2'b00};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST)) begin
                    // This wait cycle is number TIMEOUT_CYCLES: give up.
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ERROR;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                // Redirect inputs only matter here, on the accept cycle.
                if (instr_accept) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            S_ERROR: begin
                // Parked until reset; pc_q keeps the failing address.
            end
            default: state_d = S_REQ;
        endcase
    end

    // Gating with reset_n keeps the request low for the whole reset window
    // even though the state register already sits in REQ.
    assign imem_req    = reset_n && (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instruction = instr_q;
    assign instr_valid = (state_q == S_HOLD);
    assign fetch_error = (state_q == S_ERROR);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fcnt_q <= '0;
        else if ((state_q == S_REQ) && imem_ready)
            fcnt_q <= fcnt_q + 32'd1;
    end

    assign fetch_count = fcnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        instr_accept;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        zero_flag;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic        fetch_error;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .instr_accept (instr_accept),
        .branch_eq    (branch_eq),
        .branch_ne    (branch_ne),
        .jump         (jump),
        .zero_flag    (zero_flag),
        .branch_offset(branch_offset),
        .jump_index   (jump_index),
        .fetch_error  (fetch_error)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic redir(input logic j, input logic [25:0] ji, input logic beq,
                         input logic bne, input logic z, input logic [31:0] off);
        jump = j; jump_index = ji; branch_eq = beq; branch_ne = bne;
        zero_flag = z; branch_offset = off;
    endtask

    initial begin
        reset_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; instr_accept = 1'b0;
        redir(1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        step(); step();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",    pc_out, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_err",   {31'd0, fetch_error}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fcnt",  fetch_count, 32'd0);
`endif

        // Reset release with ready tied high: request in cycle 1 at addr 0
        reset_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hAAAA_0000;
        #1;
        chk("c1_req",  {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_valid",{31'd0, instr_valid}, 32'd0);
        step();
        chk("c2_valid", {31'd0, instr_valid}, 32'd1);
        chk("c2_instr", instruction, 32'hAAAA_0000);
        chk("c2_req",   {31'd0, imem_req}, 32'd0);

        // Accept every cycle: addresses 0,4,8 every 2 cycles
        instr_accept = 1'b1; imem_rdata = 32'hAAAA_0004;
        step();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_req4",  {31'd0, imem_req}, 32'd1);
        chk("seq_v4",    {31'd0, instr_valid}, 32'd0);
        step(); // accept ignored in REQ
        chk("seq_pc4_hold", pc_out, 32'h4);
        chk("seq_instr4",   instruction, 32'hAAAA_0004);
        imem_rdata = 32'hAAAA_0008;
        step();
        chk("seq_addr8", imem_addr, 32'h8);
        instr_accept = 1'b0;
        step();
        imem_rdata = 32'hDEAD_BEEF; // ignored while holding
        step();
        chk("hold_stable_instr", instruction, 32'hAAAA_0008);
        chk("hold_stable_pc",    pc_out, 32'h8);
        chk("hold_req0",         {31'd0, imem_req}, 32'd0);

        // Jump to 0x100
        redir(1'b1, 26'h40, 1'b0, 1'b0, 1'b0, 32'h0); instr_accept = 1'b1;
        step();
        chk("jmp_100", imem_addr, 32'h100);
        instr_accept = 1'b0; redir(1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // beq taken, offset -2 -> 0xFC
        redir(1'b0, 26'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE); instr_accept = 1'b1;
        step();
        chk("beq_taken", imem_addr, 32'h0FC);
        instr_accept = 1'b0; redir(1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        instr_accept = 1'b1;
        step();
        chk("seq_100", imem_addr, 32'h100);
        instr_accept = 1'b0;
        step();

        // beq not taken (zero=0) -> 0x104
        redir(1'b0, 26'h0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE); instr_accept = 1'b1;
        step();
        chk("beq_nt", imem_addr, 32'h104);
        instr_accept = 1'b0; redir(1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // Jump to 0x0040_0010
        redir(1'b1, 26'h10_0004, 1'b0, 1'b0, 1'b0, 32'h0); instr_accept = 1'b1;
        step();
        chk("jmp_400010", imem_addr, 32'h0040_0010);
        instr_accept = 1'b0;
        step();

        // Jump wins over taken beq
        redir(1'b1, 26'h000_0123, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE); instr_accept = 1'b1;
        step();
        chk("jmp_wins", imem_addr, 32'h0000_048C);
        instr_accept = 1'b0;
        step();

        // beq and bne both high -> taken regardless of zero: 0x490 + 4 = 0x494
        redir(1'b0, 26'h0, 1'b1, 1'b1, 1'b0, 32'h1); instr_accept = 1'b1;
        step();
        chk("beq_bne", imem_addr, 32'h494);
        instr_accept = 1'b0;
        step();

        // Branch to 0xFFFF_FFFC: 0x498 + 4*(-0x127)
        redir(1'b0, 26'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FED9); instr_accept = 1'b1;
        step();
        chk("br_top", imem_addr, 32'hFFFF_FFFC);
        instr_accept = 1'b0; redir(1'b0, 26'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        instr_accept = 1'b1;
        step();
        chk("pc_wrap", imem_addr, 32'h0);
        instr_accept = 1'b0;
        step();
        chk("wrap_hold_v", {31'd0, instr_valid}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("fcnt_12", fetch_count, 32'd12);
`endif

        // Reset pulse during HOLD
        imem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rhold_valid", {31'd0, instr_valid}, 32'd0);
        chk("rhold_instr", instruction, 32'h0);
        chk("rhold_req",   {31'd0, imem_req}, 32'd0);
        step();
        reset_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1111_0000;
        #1;
        chk("refetch_addr", imem_addr, 32'h0);
        chk("refetch_req",  {31'd0, imem_req}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("fcnt_rst", fetch_count, 32'd0);
`endif

        // Three fetches, then a timed-out one
        step(); instr_accept = 1'b1;
        step(); step(); step(); step();
        instr_accept = 1'b0;
        chk("f3_pc", pc_out, 32'h8);
        chk("f3_v",  {31'd0, instr_valid}, 32'd1);
        instr_accept = 1'b1;
        step();
        instr_accept = 1'b0; imem_ready = 1'b0;
        chk("to_addr", imem_addr, 32'hC);
        step(); step(); step();
        chk("to_3_err", {31'd0, fetch_error}, 32'd0);
        chk("to_3_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("to_4_err",   {31'd0, fetch_error}, 32'd1);
        chk("to_4_req",   {31'd0, imem_req}, 32'd0);
        chk("to_4_valid", {31'd0, instr_valid}, 32'd0);
        chk("to_4_pc",    pc_out, 32'hC);
        imem_ready = 1'b1; instr_accept = 1'b1;
        step(); step();
        chk("err_sticky", {31'd0, fetch_error}, 32'd1);
        chk("err_pc",     pc_out, 32'hC);
`ifdef FETCH_PERF_CNT_EN
        chk("fcnt_3", fetch_count, 32'd3);
`endif
        reset_n = 1'b0;
        #1;
        chk("err_clr", {31'd0, fetch_error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
